ring_nic: RTL and testbench

- Network interface controller sitting between the cpu's NIC port and one ring router's local port.
- It is the responder on the cpu NIC bus: it decodes cpuAddr/cpuEn/cpuWrEn and returns read data.
- It is initiator/receiver on the router-side send/ready handshake.
- Holds one-entry input and output channel buffers plus status registers. Output injection is gated by the router's even/odd polarity.

---
 rtl/ring_nic_pkg.sv | 37 +++
 rtl/ring_nic_if.sv | 28 ++
 rtl/nic_channel_buf.sv | 42 ++++
 rtl/ring_nic.sv | 67 ++++++
 tb/tb_ring_nic.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ring_nic_pkg.sv
// Shared constants and types for the ring NIC: register map, packet layout, channel states.
package ring_nic_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_STAT = 2'b11;

    // Packet field positions, bit 0 is the MSB
    localparam int unsigned PKT_VC_BIT      = 0;
    localparam int unsigned PKT_DIR_MSB     = 1;
    localparam int unsigned PKT_DIR_LSB     = 2;
    localparam int unsigned PKT_HOP_MSB     = 8;
    localparam int unsigned PKT_HOP_LSB     = 15;
    localparam int unsigned PKT_SRC_MSB     = 16;
    localparam int unsigned PKT_SRC_LSB     = 31;
    localparam int unsigned PKT_PAYLOAD_MSB = 32;
    localparam int unsigned PKT_PAYLOAD_LSB = 63;

    typedef struct packed {
        logic        vc;
        logic [1:0]  dir;
        logic [4:0]  rsvd;
        logic [7:0]  hopCount;
        logic [15:0] src;
        logic [31:0] payload;
    } packet_t;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chanState_e;

endpackage

// File: rtl/ring_nic_if.sv
// CPU NIC register bus plus router local-port handshake seen by the ring NIC.
interface ring_nic_if #(
    parameter int unsigned DATA_WIDTH = ring_nic_pkg::DATA_WIDTH
);
    logic [0:1]            cpuAddr;
    logic                  cpuEn;
    logic                  cpuWrEn;
    logic [0:DATA_WIDTH-1] cpuDataIn;
    logic [0:DATA_WIDTH-1] cpuDataOut;

    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;

    modport master (
        output cpuAddr, cpuEn, cpuWrEn, cpuDataIn, net_si, net_di, net_ro, net_polarity,
        input  cpuDataOut, net_ri, net_so, net_do
    );

    modport slave (
        input  cpuAddr, cpuEn, cpuWrEn, cpuDataIn, net_si, net_di, net_ro, net_polarity,
        output cpuDataOut, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_channel_buf.sv
// One-entry packet buffer with a full flag; load only lands when empty, clear empties it.
module nic_channel_buf #(
    parameter int unsigned DATA_WIDTH = ring_nic_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [0:DATA_WIDTH-1] dataIn,
    output logic [0:DATA_WIDTH-1] data,
    output logic                  full
);
    import ring_nic_pkg::*;

    chanState_e state;

    // Data is kept after clear so a stale read still returns the last packet
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CH_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                CH_EMPTY: begin
                    if (load) begin
                        data  <= dataIn;
                        state <= CH_FULL;
                    end
                end
                CH_FULL: begin
                    if (clear) begin
                        state <= CH_EMPTY;
                    end
                end
                default: state <= CH_EMPTY;
            endcase
        end
    end

    assign full = (state == CH_FULL);

endmodule

// File: rtl/ring_nic.sv
// Ring NIC: cpu-visible input/output buffers and status bridging to a router local port.
module ring_nic #(
    parameter int unsigned DATA_WIDTH = ring_nic_pkg::DATA_WIDTH,
    parameter int unsigned VC_BIT     = ring_nic_pkg::PKT_VC_BIT
) (
    input  logic      clk,
    input  logic      reset,
    ring_nic_if.slave bus
);
    import ring_nic_pkg::*;

    logic [0:DATA_WIDTH-1] inBuf;
    logic [0:DATA_WIDTH-1] outBuf;
    logic [0:DATA_WIDTH-1] cpuDataOutQ;
    logic                  inFull;
    logic                  outFull;
    logic                  cpuRead;
    logic                  cpuWrite;
    logic                  netSo;

    assign cpuRead  = bus.cpuEn & ~bus.cpuWrEn;
    assign cpuWrite = bus.cpuEn &  bus.cpuWrEn;

    // Injection only on a cycle whose polarity matches the packet's virtual channel
    assign netSo = outFull & bus.net_ro & (bus.net_polarity == outBuf[VC_BIT]);

    nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) inChan (
        .clk    (clk),
        .reset  (reset),
        .load   (bus.net_si),
        .clear  (cpuRead & (bus.cpuAddr == ADDR_IN_BUF)),
        .dataIn (bus.net_di),
        .data   (inBuf),
        .full   (inFull)
    );

    nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) outChan (
        .clk    (clk),
        .reset  (reset),
        .load   (cpuWrite & (bus.cpuAddr == ADDR_OUT_BUF)),
        .clear  (netSo),
        .dataIn (bus.cpuDataIn),
        .data   (outBuf),
        .full   (outFull)
    );

    // Read data mux, one cycle of latency, holds between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpuDataOutQ <= '0;
        end else if (cpuRead) begin
            case (bus.cpuAddr)
                ADDR_IN_BUF:   cpuDataOutQ <= inBuf;
                ADDR_IN_STAT:  cpuDataOutQ <= {(DATA_WIDTH-1)'(0), inFull};
                ADDR_OUT_BUF:  cpuDataOutQ <= outBuf;
                ADDR_OUT_STAT: cpuDataOutQ <= {(DATA_WIDTH-1)'(0), outFull};
                default:       cpuDataOutQ <= '0;
            endcase
        end
    end

    assign bus.cpuDataOut = cpuDataOutQ;
    assign bus.net_ri     = ~inFull;
    assign bus.net_so     = netSo;
    assign bus.net_do     = outBuf;

endmodule

// File: tb/tb_ring_nic.sv
// Directed bench for ring_nic: register map, router handshake, polarity gating, collisions, async reset.
module tb_ring_nic;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ring_nic_if #(.DATA_WIDTH(64)) bus ();

    ring_nic dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuRd(input logic [1:0] addr);
        bus.cpuEn   = 1'b1;
        bus.cpuWrEn = 1'b0;
        bus.cpuAddr = addr;
        tick();
        bus.cpuEn   = 1'b0;
    endtask

    task automatic cpuWr(input logic [1:0] addr, input logic [63:0] data);
        bus.cpuEn     = 1'b1;
        bus.cpuWrEn   = 1'b1;
        bus.cpuAddr   = addr;
        bus.cpuDataIn = data;
        tick();
        bus.cpuEn     = 1'b0;
        bus.cpuWrEn   = 1'b0;
    endtask

    task automatic netSend(input logic [63:0] data);
        bus.net_si = 1'b1;
        bus.net_di = data;
        tick();
        bus.net_si = 1'b0;
    endtask

    localparam logic [63:0] PKT_RX  = 64'h8000_0000_DEAD_BEEF;
    localparam logic [63:0] PKT_TX  = 64'h8000_0000_0000_0042;
    localparam logic [63:0] PKT_A   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_B   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] PKT_EV  = 64'h0000_0000_0000_0055;

    initial begin
        checks = 0;
        errors = 0;
        rst              = 1'b0;
        bus.cpuAddr      = 2'b00;
        bus.cpuEn        = 1'b0;
        bus.cpuWrEn      = 1'b0;
        bus.cpuDataIn    = '0;
        bus.net_si       = 1'b0;
        bus.net_di       = '0;
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_net_ri", 64'(bus.net_ri), 64'd1);
        check("rst_net_so", 64'(bus.net_so), 64'd0);
        check("rst_net_do", bus.net_do, 64'h0);
        check("rst_cpuDataOut", bus.cpuDataOut, 64'h0);
        rst = 1'b1;
        cpuRd(2'b01);
        check("rst_in_stat", bus.cpuDataOut, 64'h0);
        cpuRd(2'b11);
        check("rst_out_stat", bus.cpuDataOut, 64'h0);

        // Receive path
        netSend(PKT_RX);
        check("rx_ri_low", 64'(bus.net_ri), 64'd0);
        netSend(PKT_A);
        check("rx_full_ri_low", 64'(bus.net_ri), 64'd0);
        cpuRd(2'b01);
        check("rx_in_stat_full", bus.cpuDataOut, 64'h1);
        cpuRd(2'b00);
        check("rx_in_buf", bus.cpuDataOut, PKT_RX);
        check("rx_ri_after_read", 64'(bus.net_ri), 64'd1);
        cpuRd(2'b01);
        check("rx_in_stat_empty", bus.cpuDataOut, 64'h0);
        cpuRd(2'b00);
        check("rx_stale_read", bus.cpuDataOut, PKT_RX);
        check("rx_stale_ri", 64'(bus.net_ri), 64'd1);

        // Read of 00 clearing FULL alongside net_si: capture only on the following cycle
        netSend(PKT_A);
        bus.net_si  = 1'b1;
        bus.net_di  = PKT_B;
        cpuRd(2'b00);
        check("sim_read_data", bus.cpuDataOut, PKT_A);
        check("sim_ri_no_capture", 64'(bus.net_ri), 64'd1);
        tick();
        bus.net_si = 1'b0;
        check("sim_ri_captured", 64'(bus.net_ri), 64'd0);
        cpuRd(2'b00);
        check("sim_second_pkt", bus.cpuDataOut, PKT_B);

        // Send gated by polarity
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        cpuWr(2'b10, PKT_TX);
        check("tx_so_wrong_pol", 64'(bus.net_so), 64'd0);
        check("tx_net_do", bus.net_do, PKT_TX);
        tick();
        check("tx_so_wrong_pol_hold", 64'(bus.net_so), 64'd0);
        bus.net_polarity = 1'b1;
        #1;
        check("tx_so_right_pol", 64'(bus.net_so), 64'd1);
        tick();
        check("tx_so_after_inject", 64'(bus.net_so), 64'd0);
        check("tx_do_stale", bus.net_do, PKT_TX);
        cpuRd(2'b11);
        check("tx_out_stat_empty", bus.cpuDataOut, 64'h0);

        // Backpressure and dropped write while full
        bus.net_ro = 1'b0;
        cpuWr(2'b10, PKT_TX);
        for (int i = 0; i < 5; i++) begin
            check("bp_so_low", 64'(bus.net_so), 64'd0);
            tick();
        end
        cpuWr(2'b10, 64'h1);
        cpuRd(2'b10);
        check("bp_write_dropped", bus.cpuDataOut, PKT_TX);
        cpuRd(2'b11);
        check("bp_out_stat_full", bus.cpuDataOut, 64'h1);

        // Injection and cpu write in the same cycle
        bus.net_ro = 1'b1;
        #1;
        check("col_so_high", 64'(bus.net_so), 64'd1);
        cpuWr(2'b10, 64'h7);
        check("col_so_low", 64'(bus.net_so), 64'd0);
        cpuRd(2'b10);
        check("col_out_buf_old", bus.cpuDataOut, PKT_TX);
        cpuRd(2'b11);
        check("col_out_stat", bus.cpuDataOut, 64'h0);

        // Async reset with both channels full
        netSend(PKT_A);
        cpuWr(2'b10, PKT_EV);
        cpuRd(2'b10);
        check("ar_pre_cpuDataOut", bus.cpuDataOut, PKT_EV);
        check("ar_pre_so_gated", 64'(bus.net_so), 64'd0);
        bus.net_polarity = 1'b0;
        #1;
        check("ar_pre_so", 64'(bus.net_so), 64'd1);
        check("ar_pre_ri", 64'(bus.net_ri), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        check("ar_ri", 64'(bus.net_ri), 64'd1);
        check("ar_so", 64'(bus.net_so), 64'd0);
        check("ar_do", bus.net_do, 64'h0);
        check("ar_cpuDataOut", bus.cpuDataOut, 64'h0);
        tick();
        rst = 1'b1;
        cpuRd(2'b01);
        check("ar_in_stat", bus.cpuDataOut, 64'h0);
        cpuRd(2'b11);
        check("ar_out_stat", bus.cpuDataOut, 64'h0);
        cpuRd(2'b00);
        check("ar_in_buf", bus.cpuDataOut, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
